pixel_block_scheduler: RTL and testbench

- Sequences the RGB pixel memory for the compression datapath.
- Captures the frame size and walks the image in 8x8 block order: blocks left-to-right then top-to-bottom, and raster order inside each block.
- Issues one read enable and address per pixel and tags the returning pixels with block position, in-block index and end-of-block.
- Sits between the frame-level control and the memory and its downstream consumer (colour conversion and DCT).

---
 rtl/pixel_block_scheduler.sv | 114 +++++++++++
 tb/tb_pixel_block_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_block_scheduler.sv
// pixel_block_scheduler: walks a frame in 8x8 block order, issuing pixel reads and tagging returned pixels.
module pixel_block_scheduler #(
  parameter int ADDR_W   = 20,
  parameter int DIM_W    = 32,
  parameter int BLK_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DIM_W-1:0]        size_x,
  input  logic [DIM_W-1:0]        size_y,
  input  logic                    dn_ready,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  output logic                    pix_valid,
  output logic [2*BLK_LOG2-1:0]   pix_idx,
  output logic [DIM_W-1:0]        blk_x,
  output logic [DIM_W-1:0]        blk_y,
  output logic                    blk_last,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    size_err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [BLK_LOG2-1:0] M = '1;
  localparam logic [2*DIM_W-1:0] MAX_AREA = (2*DIM_W)'(1) << ADDR_W;
  state_t state;
  logic [DIM_W-1:0] sx, sy, bx, by;
  logic [BLK_LOG2-1:0] r, c;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [2*DIM_W-1:0] area;
  logic legal, c_end, r_end, bx_end, by_end;
  assign area   = {{DIM_W{1'b0}}, size_x} * {{DIM_W{1'b0}}, size_y};
  assign legal  = size_x != '0 && size_y != '0 && size_x[BLK_LOG2-1:0] == '0 &&
                  size_y[BLK_LOG2-1:0] == '0 && area <= MAX_AREA;
  assign c_end  = c == M;
  assign r_end  = r == M;
  assign bx_end = bx == (sx >> BLK_LOG2) - DIM_W'(1);
  assign by_end = by == (sy >> BLK_LOG2) - DIM_W'(1);
  assign rd_en  = state == RUN && dn_ready;
  assign rd_addr = addr;
  assign busy   = state != IDLE;
  // Next row in block: +sx-7; next block in row: back up 7 rows, +1; next block row is contiguous.
  always_comb begin
    addr_nxt = !c_end ? addr + ADDR_W'(1)
             : !r_end ? addr + ADDR_W'(sx) - ADDR_W'(M)
             : !bx_end ? addr + ADDR_W'(1) - ADDR_W'(M) * ADDR_W'(sx)
             : addr + ADDR_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sx         <= '0;
      sy         <= '0;
      bx         <= '0;
      by         <= '0;
      r          <= '0;
      c          <= '0;
      addr       <= '0;
      pix_valid  <= 1'b0;
      pix_idx    <= '0;
      blk_x      <= '0;
      blk_y      <= '0;
      blk_last   <= 1'b0;
      frame_done <= 1'b0;
      size_err   <= 1'b0;
    end else begin
      pix_valid  <= rd_en;
      blk_last   <= rd_en && c_end && r_end;
      frame_done <= 1'b0;
      if (rd_en) begin
        pix_idx <= {r, c};
        blk_x   <= bx;
        blk_y   <= by;
      end
      if (abort) state <= IDLE;
      else case (state)
        IDLE: if (start) begin
          size_err <= !legal;
          if (legal) begin
            sx    <= size_x;
            sy    <= size_y;
            bx    <= '0;
            by    <= '0;
            r     <= '0;
            c     <= '0;
            addr  <= '0;
            state <= RUN;
          end
        end
        RUN: if (rd_en) begin
          addr <= addr_nxt;
          c    <= c + 1'b1;
          if (c_end) begin
            r <= r + 1'b1;
            if (r_end) begin
              bx <= bx_end ? '0 : bx + DIM_W'(1);
              if (bx_end) begin
                by <= by + DIM_W'(1);
                if (by_end) state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          state      <= DONE;
          frame_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_block_scheduler.sv
// tb_pixel_block_scheduler: directed frames with a reference address/tag model and event timing checks.
module tb_pixel_block_scheduler;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, dn_ready = 1;
  logic [31:0] size_x = 0, size_y = 0;
  logic rd_en, pix_valid, blk_last, busy, frame_done, size_err;
  logic [19:0] rd_addr;
  logic [5:0] pix_idx;
  logic [31:0] blk_x, blk_y;
  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0, exp_sx = 8;
  int rd_cnt, pv_cnt, done_cnt, addr_bad, idx_bad, orphan, first_rd, last_rd, done_cyc, busy_low;
  bit prev_rd, toggle;
  int bl_q[$];

  pixel_block_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .size_x(size_x), .size_y(size_y),
    .dn_ready(dn_ready), .rd_en(rd_en), .rd_addr(rd_addr), .pix_valid(pix_valid), .pix_idx(pix_idx),
    .blk_x(blk_x), .blk_y(blk_y), .blk_last(blk_last), .busy(busy), .frame_done(frame_done),
    .size_err(size_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(int k);
    int b, i, nbx;
    nbx = exp_sx / 8;
    b = k / 64;
    i = k % 64;
    return ((b / nbx) * 8 + i / 8) * exp_sx + (b % nbx) * 8 + i % 8;
  endfunction

  task automatic clr();
    rd_cnt = 0; pv_cnt = 0; done_cnt = 0; addr_bad = 0; idx_bad = 0; orphan = 0;
    first_rd = -1; last_rd = -1; done_cyc = -1; busy_low = -1; prev_rd = 0;
    bl_q.delete();
  endtask

  always @(negedge clk) if (rst_n) begin
    int rel, b, nbx;
    rel = cyc - t0;
    nbx = exp_sx / 8;
    if (rd_en) begin
      if (rd_addr !== 20'(exp_addr(rd_cnt))) addr_bad++;
      if (rd_cnt == 0) first_rd = rel;
      last_rd = rel;
      rd_cnt++;
    end
    if (pix_valid) begin
      b = pv_cnt / 64;
      if (!prev_rd) orphan++;
      if (pix_idx !== 6'(pv_cnt % 64) || blk_x !== 32'(b % nbx) || blk_y !== 32'(b / nbx) ||
          blk_last !== (pv_cnt % 64 == 63)) idx_bad++;
      if (blk_last) bl_q.push_back(rel);
      pv_cnt++;
    end else if (blk_last) orphan++;
    if (frame_done) begin
      done_cnt++;
      done_cyc = rel;
    end
    if (done_cnt > 0 && !busy && busy_low < 0) busy_low = rel;
    prev_rd = rd_en;
  end

  task automatic step();
    @(posedge clk);
    #1;
    dn_ready = toggle ? ((cyc - t0) % 2 == 1) : 1'b1;
  endtask

  task automatic start_frame(input int x, input int y);
    size_x = x;
    size_y = y;
    start = 1;
    t0 = cyc;
    clr();
    step();
    start = 0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit && done_cnt == 0; i++) step();
    step();
    step();
    chk({tag, "_done"}, done_cnt, 1);
  endtask

  initial begin
    clr();
    repeat (2) step();
    chk("rst_flags", {rd_en, busy, pix_valid, frame_done, blk_last, size_err}, 0);
    chk("rst_addr", rd_addr, 0);
    rst_n = 1;
    step();

    // 16x8 frame, full throughput
    exp_sx = 16;
    start_frame(16, 8);
    wait_done("f16x8", 300);
    chk("f16x8_first_rd", first_rd, 1);
    chk("f16x8_last_rd", last_rd, 128);
    chk("f16x8_rd_cnt", rd_cnt, 128);
    chk("f16x8_pv_cnt", pv_cnt, 128);
    chk("f16x8_addr", addr_bad, 0);
    chk("f16x8_tags", idx_bad, 0);
    chk("f16x8_bl_cnt", bl_q.size(), 2);
    if (bl_q.size() == 2) begin
      chk("f16x8_bl0", bl_q[0], 65);
      chk("f16x8_bl1", bl_q[1], 129);
    end
    chk("f16x8_done_cyc", done_cyc, 130);
    chk("f16x8_busy_low", busy_low, 131);

    // 8x8 with dn_ready alternating
    exp_sx = 8;
    toggle = 1;
    start_frame(8, 8);
    wait_done("tog", 400);
    toggle = 0;
    chk("tog_rd_cnt", rd_cnt, 64);
    chk("tog_last_rd", last_rd, 127);
    chk("tog_orphan", orphan, 0);
    chk("tog_addr", addr_bad, 0);
    chk("tog_tags", idx_bad, 0);

    // illegal sizes and the 2^ADDR_W area boundary
    start_frame(12, 8);
    step();
    chk("ill12_err", size_err, 1);
    chk("ill12_busy", busy, 0);
    chk("ill12_rd", rd_cnt, 0);
    start_frame(1024, 1024);
    chk("max_area_ok", {busy, size_err}, 2'b10);
    abort = 1;
    step();
    abort = 0;
    chk("max_area_abort", busy, 0);
    start_frame(2048, 1024);
    step();
    chk("ill_area_err", {busy, size_err}, 2'b01);
    start_frame(0, 8);
    step();
    chk("ill0_err", {busy, size_err}, 2'b01);
    start_frame(8, 8);
    chk("legal_clr_err", {busy, size_err}, 2'b10);
    wait_done("legal8", 200);
    chk("legal8_rd_cnt", rd_cnt, 64);
    chk("legal8_addr", addr_bad, 0);

    // abort+start together in IDLE: abort wins
    abort = 1;
    start_frame(8, 8);
    abort = 0;
    step();
    chk("abort_start_idle", {busy, rd_cnt[0]}, 0);

    // 16x16 abort at the 70th read
    exp_sx = 16;
    start_frame(16, 16);
    while (cyc - t0 < 70) step();
    abort = 1;
    step();
    abort = 0;
    chk("abort_next", {rd_en, busy}, 0);
    repeat (5) step();
    chk("abort_rd_cnt", rd_cnt, 70);
    chk("abort_pv_cnt", pv_cnt, 70);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_addr", addr_bad, 0);
    exp_sx = 8;
    start_frame(8, 8);
    wait_done("post_abort", 200);
    chk("post_abort_first", first_rd, 1);
    chk("post_abort_addr", addr_bad, 0);

    // asynchronous reset mid-frame
    exp_sx = 16;
    start_frame(16, 8);
    while (cyc - t0 < 30) step();
    rst_n = 0;
    #1;
    chk("arst_flags", {rd_en, busy, pix_valid, frame_done, blk_last, size_err}, 0);
    chk("arst_addr_idx", {rd_addr, pix_idx}, 0);
    step();
    rst_n = 1;
    clr();
    repeat (3) step();
    chk("arst_no_trail", pv_cnt + rd_cnt + busy, 0);
    exp_sx = 8;
    start_frame(8, 8);
    wait_done("post_rst", 200);
    chk("post_rst_rd_cnt", rd_cnt, 64);
    chk("post_rst_addr", addr_bad, 0);

    // start while busy with other sizes is ignored
    exp_sx = 16;
    start_frame(16, 8);
    while (cyc - t0 < 20) step();
    size_x = 8;
    size_y = 8;
    start = 1;
    step();
    start = 0;
    wait_done("restart", 300);
    chk("restart_rd_cnt", rd_cnt, 128);
    chk("restart_addr", addr_bad, 0);
    chk("restart_tags", idx_bad, 0);
    chk("restart_done_cyc", done_cyc, 130);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
